// File: rtl/gs232c_pipe_iq_pkg.sv
// Shared definitions for the gs232c instruction queue: entry field widths,
// group/decode widths, the queue entry layout and the group-size helper.
package gs232c_pipe_iq_pkg;

    localparam int INST_W   = 32;
    localparam int PC_W     = 30;
    localparam int HINT_W   = 4;
    localparam int REDIR_W  = 1;
    localparam int ENTRY_W  = INST_W + PC_W + HINT_W + REDIR_W;  // 67
    localparam int GROUP_W  = 4;   // instructions per fetch group
    localparam int DECODE_W = 2;   // instructions presented to decode

    // One queue entry; the PC is stored word-aligned without its low two bits.
    typedef struct packed {
        logic [REDIR_W-1:0] redir;
        logic [HINT_W-1:0]  hint;
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
    } iq_entry_t;

    // Number of instructions in a group starting at word offset word_off of a
    // 32-byte line; a group never runs past the end of its line.
    function automatic logic [2:0] group_size(input logic [2:0] word_off);
        logic [3:0] room;
        room = 4'd8 - {1'b0, word_off};
        return (room > 4'd4) ? 3'd4 : room[2:0];
    endfunction

endpackage

// File: rtl/gs232c_pipe_iq_ram.sv
// Entry storage for the instruction queue: DEPTH x ENTRY_W register array with
// GROUP_W write ports at consecutive addresses from one base and two
// combinational read ports.
module gs232c_iq_ram
    import gs232c_pipe_iq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                       clock,
    input  logic [GROUP_W-1:0]         wr_en,
    input  logic [PTR_W-1:0]           wr_base,
    input  logic [GROUP_W*ENTRY_W-1:0] wr_data,
    input  logic [PTR_W-1:0]           rd_addr0,
    input  logic [PTR_W-1:0]           rd_addr1,
    output logic [ENTRY_W-1:0]         rd_data0,
    output logic [ENTRY_W-1:0]         rd_data1
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Port k writes address wr_base+k (wrapping); enabled ports never collide.
    always_ff @(posedge clock) begin
        for (int k = 0; k < GROUP_W; k++) begin
            if (wr_en[k]) begin
                mem[wr_base + PTR_W'(k)] <= wr_data[k*ENTRY_W +: ENTRY_W];
            end
        end
    end

    assign rd_data0 = mem[rd_addr0];
    assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/gs232c_pipe_iq.sv
// Instruction queue between the fetch-group stage and decode. Splits each
// accepted group into per-instruction entries of a circular buffer and
// presents up to two entries per cycle to decode.
// Optional same-cycle bypass of an empty queue: define GS232C_IQ_BYPASS_EN.
//
// Handshakes: a fetch group transfers on a cycle where fe_go is high (fe_go
// already folds in fe_valid and inst_valid). Decode sees a thermometer
// de_valid and returns a thermometer de_accept that is a subset of it; each
// accepted instruction is popped at the next edge. A cancel drops everything.
module gs232c_pipe_iq
    import gs232c_pipe_iq_pkg::*;
#(
    parameter int IQ_DEPTH = 8,
    parameter int IQ_PTR_W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         fe_valid,
    input  logic [31:0]  fe_cur,
    input  logic [15:0]  fe_hint,
    input  logic         fe_is_seq,
    output logic         fe_go,
    input  logic         inst_valid,
    input  logic [127:0] inst_rdata,
    input  logic         br_cancel,
    input  logic         wb_cancel,
    output logic         iq_cancel,
    output logic [1:0]   de_valid,
    output logic [31:0]  de_inst0,
    output logic [31:0]  de_inst1,
    output logic [31:0]  de_pc0,
    output logic [31:0]  de_pc1,
    output logic [3:0]   de_hint0,
    output logic [3:0]   de_hint1,
    output logic         de_redir0,
    output logic         de_redir1,
    input  logic [1:0]   de_accept
);

    localparam int CNT_W = IQ_PTR_W + 1;

    logic [IQ_PTR_W-1:0]        head;
    logic [IQ_PTR_W-1:0]        tail;
    logic [CNT_W-1:0]           count;
    logic [2:0]                 n_in;
    logic [CNT_W-1:0]           free_slots;
    logic [1:0]                 pop;
    logic [1:0]                 skip;
    logic [1:0]                 deq_n;
    logic [2:0]                 enq_n;
    logic                       byp_active;
    logic [GROUP_W-1:0]         wr_en;
    logic [GROUP_W*ENTRY_W-1:0] wr_data;
    iq_entry_t                  rd0;
    iq_entry_t                  rd1;
    logic                       unused_byte_offset;

    assign unused_byte_offset = &{1'b0, fe_cur[1:0]};

    assign iq_cancel  = br_cancel | wb_cancel;
    assign n_in       = group_size(fe_cur[4:2]);
    // Space is judged on the occupancy before this cycle's pops.
    assign free_slots = CNT_W'(IQ_DEPTH) - count;
    assign fe_go      = fe_valid && inst_valid && !iq_cancel && !reset
                        && (free_slots >= CNT_W'(n_in));
    assign pop        = {1'b0, de_accept[0]} + {1'b0, de_accept[1]};

`ifdef GS232C_IQ_BYPASS_EN
    assign byp_active = fe_go && (count == '0);
`else
    assign byp_active = 1'b0;
`endif

    // Bypassed-and-accepted slots never enter the buffer; pops on a bypass
    // cycle consume those slots rather than stored entries.
    assign skip  = byp_active ? pop : 2'd0;
    assign enq_n = fe_go ? (n_in - {1'b0, skip}) : 3'd0;
    assign deq_n = byp_active ? 2'd0 : pop;

    // Map group slots skip..n_in-1 onto write ports 0..enq_n-1.
    always_comb begin
        wr_en   = '0;
        wr_data = '0;
        for (int k = 0; k < GROUP_W; k++) begin
            int        s;
            iq_entry_t e;
            s = k + int'(skip);
            e = '0;
            if ((3'(k) < enq_n) && (s < GROUP_W)) begin
                e.inst   = inst_rdata[s*INST_W +: INST_W];
                e.pc     = fe_cur[31:2] + PC_W'(s);
                e.hint   = fe_hint[s*HINT_W +: HINT_W];
                e.redir  = !fe_is_seq && (s == 0);
                wr_en[k] = 1'b1;
            end
            wr_data[k*ENTRY_W +: ENTRY_W] = e;
        end
    end

    gs232c_iq_ram #(
        .DEPTH (IQ_DEPTH),
        .PTR_W (IQ_PTR_W)
    ) u_ram (
        .clock    (clock),
        .wr_en    (wr_en),
        .wr_base  (tail),
        .wr_data  (wr_data),
        .rd_addr0 (head),
        .rd_addr1 (head + IQ_PTR_W'(1)),
        .rd_data0 (rd0),
        .rd_data1 (rd1)
    );

    // Pointer and occupancy update; cancel and reset empty the queue.
    always_ff @(posedge clock) begin
        if (reset || iq_cancel) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + IQ_PTR_W'(deq_n);
            tail  <= tail + IQ_PTR_W'(enq_n);
            count <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    // Decode-side view: stored head entries, or the incoming group on bypass.
    always_comb begin
        de_valid  = reset ? 2'b00 : {count >= CNT_W'(2), count >= CNT_W'(1)};
        de_inst0  = rd0.inst;
        de_inst1  = rd1.inst;
        de_pc0    = {rd0.pc, 2'b00};
        de_pc1    = {rd1.pc, 2'b00};
        de_hint0  = rd0.hint;
        de_hint1  = rd1.hint;
        de_redir0 = rd0.redir[0];
        de_redir1 = rd1.redir[0];
`ifdef GS232C_IQ_BYPASS_EN
        if (byp_active) begin
            de_valid  = (n_in >= 3'd2) ? 2'b11 : 2'b01;
            de_inst0  = inst_rdata[31:0];
            de_inst1  = inst_rdata[63:32];
            de_pc0    = {fe_cur[31:2], 2'b00};
            de_pc1    = {fe_cur[31:2] + 30'd1, 2'b00};
            de_hint0  = fe_hint[3:0];
            de_hint1  = fe_hint[7:4];
            de_redir0 = !fe_is_seq;
            de_redir1 = 1'b0;
        end
`endif
    end

    // Decode may only take what is offered, lowest slot first.
    a_accept_subset: assert property (@(posedge clock) disable iff (reset)
        ((de_accept & ~de_valid) == 2'b00) && (de_accept != 2'b10));

endmodule

// File: tb/tb_gs232c_pipe_iq.sv
// Directed bench for gs232c_pipe_iq: fill/full, line-end truncation, flush,
// reset, optional bypass and a wrapping 4-in/2-out stream against a queue.
module tb_gs232c_pipe_iq;

    logic         clock = 1'b0;
    logic         reset;
    logic         fe_valid;
    logic [31:0]  fe_cur;
    logic [15:0]  fe_hint;
    logic         fe_is_seq;
    logic         fe_go;
    logic         inst_valid;
    logic [127:0] inst_rdata;
    logic         br_cancel;
    logic         wb_cancel;
    logic         iq_cancel;
    logic [1:0]   de_valid;
    logic [31:0]  de_inst0, de_inst1, de_pc0, de_pc1;
    logic [3:0]   de_hint0, de_hint1;
    logic         de_redir0, de_redir1;
    logic [1:0]   de_accept;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    gs232c_pipe_iq dut (
        .clock      (clock),
        .reset      (reset),
        .fe_valid   (fe_valid),
        .fe_cur     (fe_cur),
        .fe_hint    (fe_hint),
        .fe_is_seq  (fe_is_seq),
        .fe_go      (fe_go),
        .inst_valid (inst_valid),
        .inst_rdata (inst_rdata),
        .br_cancel  (br_cancel),
        .wb_cancel  (wb_cancel),
        .iq_cancel  (iq_cancel),
        .de_valid   (de_valid),
        .de_inst0   (de_inst0),
        .de_inst1   (de_inst1),
        .de_pc0     (de_pc0),
        .de_pc1     (de_pc1),
        .de_hint0   (de_hint0),
        .de_hint1   (de_hint1),
        .de_redir0  (de_redir0),
        .de_redir1  (de_redir1),
        .de_accept  (de_accept)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic go();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle, still well away from any edge.
    task automatic settle();
        #2;
    endtask

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive_group(input logic [31:0] pc, input logic seq);
        fe_valid   = 1'b1;
        inst_valid = 1'b1;
        fe_cur     = pc;
        fe_is_seq  = seq;
        fe_hint    = 16'h4321;
        for (int k = 0; k < 4; k++) inst_rdata[k*32 +: 32] = iw(pc + 32'(4*k));
    endtask

    task automatic idle();
        fe_valid   = 1'b0;
        inst_valid = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int          mcount;
        logic [31:0] npc;
        logic        exp_go;
        logic        byp;
        logic [1:0]  ev;

        reset = 1'b1; br_cancel = 1'b0; wb_cancel = 1'b0; de_accept = 2'b00;
        fe_cur = '0; fe_hint = '0; fe_is_seq = 1'b1; inst_rdata = '0;
        idle();

        // Reset: a valid group is refused and nothing is presented.
        drive_group(32'h1C00_0000, 1'b1);
        go(); settle();
        chk("rst_fe_go", fe_go, 0);
        chk("rst_de_valid", de_valid, 0);
        go();
        reset = 1'b0; idle(); settle();
        chk("post_rst_de_valid", de_valid, 0);
        chk("post_rst_count", dut.count, 0);

        // Aligned fill to full.
        drive_group(32'h1C00_0000, 1'b1); settle();
        chk("fill1_fe_go", fe_go, 1);
        go();
        drive_group(32'h1C00_0010, 1'b1); settle();
        chk("fill2_fe_go", fe_go, 1);
        chk("fill_de_valid", de_valid, 2'b11);
        chk("fill_pc0", de_pc0, 32'h1C00_0000);
        chk("fill_pc1", de_pc1, 32'h1C00_0004);
        chk("fill_inst0", de_inst0, iw(32'h1C00_0000));
        chk("fill_hint0", de_hint0, 4'h1);
        chk("fill_hint1", de_hint1, 4'h2);
        chk("fill_redir0", de_redir0, 0);
        go();
        drive_group(32'h1C00_0020, 1'b1); settle();
        chk("full_count", dut.count, 8);
        chk("full_fe_go", fe_go, 0);
        chk("full_pc0", de_pc0, 32'h1C00_0000);
        // Full with a pop this cycle still stalls the group.
        de_accept = 2'b11; settle();
        chk("full_pop_fe_go", fe_go, 0);
        go();
        de_accept = 2'b00; settle();
        chk("pop_count", dut.count, 6);
        chk("pop_pc0", de_pc0, 32'h1C00_0008);
        chk("pop_pc1", de_pc1, 32'h1C00_000C);
        chk("pop_hint0", de_hint0, 4'h3);

        // Flush at count 6 with a group offered.
        br_cancel = 1'b1; settle();
        chk("br_iq_cancel", iq_cancel, 1);
        chk("br_fe_go", fe_go, 0);
        go();
        br_cancel = 1'b0; idle(); settle();
        chk("br_de_valid", de_valid, 0);
        chk("br_count", dut.count, 0);

        // wb_cancel blocks a group; the redirect group then lands.
        wb_cancel = 1'b1; drive_group(32'h1C00_0100, 1'b0); settle();
        chk("wb_iq_cancel", iq_cancel, 1);
        chk("wb_fe_go", fe_go, 0);
        go();
        wb_cancel = 1'b0; settle();
        chk("wb_de_valid", de_valid, 0);
        chk("redir_fe_go", fe_go, 1);
        go();
        idle(); settle();
        chk("redir_redir0", de_redir0, 1);
        chk("redir_redir1", de_redir1, 0);
        chk("redir_pc0", de_pc0, 32'h1C00_0100);
        chk("redir_pc1", de_pc1, 32'h1C00_0104);
        chk("redir_count", dut.count, 4);
        de_accept = 2'b11; go(); go();
        de_accept = 2'b00; settle();
        chk("drain_de_valid", de_valid, 0);

        // Line-end truncation: only two instructions enter.
        drive_group(32'h1C00_0018, 1'b1); settle();
        chk("trunc_fe_go", fe_go, 1);
        go();
        idle(); settle();
        chk("trunc_count", dut.count, 2);
        chk("trunc_pc0", de_pc0, 32'h1C00_0018);
        chk("trunc_pc1", de_pc1, 32'h1C00_001C);
        chk("trunc_inst1", de_inst1, iw(32'h1C00_001C));
        chk("trunc_hint1", de_hint1, 4'h2);
        de_accept = 2'b11; go();
        de_accept = 2'b00; settle();
        chk("trunc_empty", de_valid, 0);

        // Reset mid-operation at count 5 (4 + single-instruction group).
        drive_group(32'h1C00_0200, 1'b1); settle(); go();
        drive_group(32'h1C00_021C, 1'b1); settle();
        chk("one_fe_go", fe_go, 1);
        go();
        idle(); settle();
        chk("five_count", dut.count, 5);
        reset = 1'b1; go();
        reset = 1'b0; settle();
        chk("mid_rst_de_valid", de_valid, 0);
        chk("mid_rst_count", dut.count, 0);
        drive_group(32'h1C00_0300, 1'b1); settle(); go();
        idle(); de_accept = 2'b01; settle();
        chk("after_rst_valid", de_valid, 2'b11);
        chk("after_rst_pc0", de_pc0, 32'h1C00_0300);
        go();
        de_accept = 2'b00; settle();
        chk("after_rst_pc0b", de_pc0, 32'h1C00_0304);
        chk("after_rst_count", dut.count, 3);
        br_cancel = 1'b1; go();
        br_cancel = 1'b0; settle();

        // Empty queue meeting a new group.
`ifdef GS232C_IQ_BYPASS_EN
        drive_group(32'h1C00_0040, 1'b1); de_accept = 2'b11; settle();
        chk("byp_fe_go", fe_go, 1);
        chk("byp_de_valid", de_valid, 2'b11);
        chk("byp_pc0", de_pc0, 32'h1C00_0040);
        chk("byp_pc1", de_pc1, 32'h1C00_0044);
        go();
        idle(); de_accept = 2'b00; settle();
        chk("byp_count", dut.count, 2);
        chk("byp_head_pc", de_pc0, 32'h1C00_0048);
`else
        drive_group(32'h1C00_0040, 1'b1); settle();
        chk("nobyp_fe_go", fe_go, 1);
        chk("nobyp_de_valid", de_valid, 0);
        go();
        idle(); settle();
        chk("nobyp_count", dut.count, 4);
        chk("nobyp_head_pc", de_pc0, 32'h1C00_0040);
`endif
        br_cancel = 1'b1; go();
        br_cancel = 1'b0; settle();

        // Steady 4-in/2-out stream across pointer wrap.
        mcount = 0;
        npc    = 32'h1C00_1000;
        exp_q.delete();
        for (int c = 0; c < 28; c++) begin
            if (c < 20) drive_group(npc, 1'b1);
            else idle();
            exp_go = (c < 20) && (8 - mcount >= 4);
            byp = 1'b0;
`ifdef GS232C_IQ_BYPASS_EN
            byp = exp_go && (mcount == 0);
`endif
            if (byp) for (int k = 0; k < 4; k++) exp_q.push_back(npc + 32'(4*k));
            ev = byp ? 2'b11 : (mcount >= 2) ? 2'b11 : (mcount >= 1) ? 2'b01 : 2'b00;
            de_accept = ev; settle();
            chk("wrap_fe_go", fe_go, 32'(exp_go));
            chk("wrap_de_valid", de_valid, 32'(ev));
            if (ev[0] && exp_q.size() > 0) chk("wrap_pc0", de_pc0, exp_q[0]);
            if (ev[1] && exp_q.size() > 1) chk("wrap_pc1", de_pc1, exp_q[1]);
            if (ev[0] && exp_q.size() > 0) void'(exp_q.pop_front());
            if (ev[1] && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_go && !byp) for (int k = 0; k < 4; k++) exp_q.push_back(npc + 32'(4*k));
            if (exp_go) npc = npc + 32'd16;
            mcount = mcount + (exp_go ? 4 : 0) - int'(ev[0]) - int'(ev[1]);
            go();
        end
        de_accept = 2'b00; settle();
        chk("wrap_end_count", dut.count, 32'(mcount));
        chk("wrap_q_left", 32'(exp_q.size()), 0);
        chk("wrap_end_valid", de_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
